// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the Harvard MIPS-I core.
// Holds the opcode / SPECIAL funct / REGIMM rt encodings, the reset vector,
// the halt address, well-known register numbers and an immediate helper.
package mips_cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;
  localparam logic [4:0]  REG_V0       = 5'd2;
  localparam logic [4:0]  REG_RA       = 5'd31;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_REGIMM  = 6'h01,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDIU   = 6'h09,
    OP_SLTI    = 6'h0A,
    OP_SLTIU   = 6'h0B,
    OP_ANDI    = 6'h0C,
    OP_ORI     = 6'h0D,
    OP_XORI    = 6'h0E,
    OP_LUI     = 6'h0F,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_JR   = 6'h08,
    FN_JALR = 6'h09,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_e;

  typedef enum logic [4:0] {
    RI_BLTZ   = 5'h00,
    RI_BGEZ   = 5'h01,
    RI_BLTZAL = 5'h10,
    RI_BGEZAL = 5'h11
  } regimm_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_cpu_regfile.sv
// 32 x 32-bit general purpose register file.
// Ports: i_clk, i_rst (async, active-high), i_we/i_waddr/i_wdata write port,
// i_raddr_a/o_rdata_a and i_raddr_b/o_rdata_b combinational read ports,
// o_v0 live tap of register $2.
// Register $0 reads as zero and ignores writes.
module mips_cpu_regfile
  import mips_cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  output logic [31:0] o_rdata_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_b,
  output logic [31:0] o_v0
);

  logic [31:0] r_regs [32] = '{default: '0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
  assign o_v0      = r_regs[REG_V0];

endmodule

// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-I integer core, Harvard buses, halts when PC reaches 0.
// Ports: clk, reset (async, active-high), clk_enable (state holds when 0),
// active (0 once halted), register_v0 (live $2), instr_address/instr_readdata
// (combinational fetch), data_address/data_write/data_read/data_writedata/
// data_readdata (word-wide combinational-read data port).
// Optional: define MIPS_CPU_TRACE_EN to $display each retired instruction.
module mips_cpu_harvard_core
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  logic [31:0] r_pc             = RESET_VECTOR;
  logic        r_branch_pending = 1'b0;
  logic [31:0] r_branch_target  = RESET_VECTOR;

  opcode_e     w_op;
  funct_e      w_fn;
  regimm_e     w_ri;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [31:0] w_rs_val, w_rt_val, w_simm, w_zimm, w_pc4, w_pc8;
  logic        w_active, w_commit;
  logic        w_wen, w_take, w_is_lw, w_is_sw;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata, w_target;

  assign w_op    = opcode_e'(instr_readdata[31:26]);
  assign w_fn    = funct_e'(instr_readdata[5:0]);
  assign w_rs    = instr_readdata[25:21];
  assign w_rt    = instr_readdata[20:16];
  assign w_rd    = instr_readdata[15:11];
  assign w_shamt = instr_readdata[10:6];
  assign w_ri    = regimm_e'(w_rt);
  assign w_simm  = sext16(instr_readdata[15:0]);
  assign w_zimm  = {16'd0, instr_readdata[15:0]};
  assign w_pc4   = r_pc + 32'd4;
  assign w_pc8   = r_pc + 32'd8;

  assign w_active = (r_pc != HALT_ADDR);
  assign w_commit = clk_enable && w_active;

  mips_cpu_regfile u_regfile (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_we      (w_commit && w_wen),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rs_val),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rt_val),
    .o_v0      (register_v0)
  );

  always_comb begin
    w_wen    = 1'b0;
    w_waddr  = w_rt;
    w_wdata  = '0;
    w_take   = 1'b0;
    w_target = w_pc4 + (w_simm << 2);
    w_is_lw  = 1'b0;
    w_is_sw  = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        w_waddr = w_rd;
        w_wen   = 1'b1;
        case (w_fn)
          FN_SLL:  w_wdata = w_rt_val << w_shamt;
          FN_SRL:  w_wdata = w_rt_val >> w_shamt;
          FN_SRA:  w_wdata = $signed(w_rt_val) >>> w_shamt;
          FN_JR:   begin w_wen = 1'b0; w_take = 1'b1; w_target = w_rs_val; end
          FN_JALR: begin w_take = 1'b1; w_target = w_rs_val; w_wdata = w_pc8; end
          FN_ADDU: w_wdata = w_rs_val + w_rt_val;
          FN_SUBU: w_wdata = w_rs_val - w_rt_val;
          FN_AND:  w_wdata = w_rs_val & w_rt_val;
          FN_OR:   w_wdata = w_rs_val | w_rt_val;
          FN_XOR:  w_wdata = w_rs_val ^ w_rt_val;
          FN_SLT:  w_wdata = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)};
          FN_SLTU: w_wdata = {31'd0, w_rs_val < w_rt_val};
          default: w_wen = 1'b0;
        endcase
      end
      OP_REGIMM: begin
        // Linking forms write $31 whether or not the branch is taken.
        w_waddr = REG_RA;
        w_wdata = w_pc8;
        case (w_ri)
          RI_BLTZ:   w_take = w_rs_val[31];
          RI_BGEZ:   w_take = !w_rs_val[31];
          RI_BLTZAL: begin w_take = w_rs_val[31];  w_wen = 1'b1; end
          RI_BGEZAL: begin w_take = !w_rs_val[31]; w_wen = 1'b1; end
          default:   ;
        endcase
      end
      OP_J:     begin w_take = 1'b1; w_target = {w_pc4[31:28], instr_readdata[25:0], 2'b00}; end
      OP_JAL:   begin
        w_take   = 1'b1;
        w_target = {w_pc4[31:28], instr_readdata[25:0], 2'b00};
        w_wen    = 1'b1;
        w_waddr  = REG_RA;
        w_wdata  = w_pc8;
      end
      OP_BEQ:   w_take = (w_rs_val == w_rt_val);
      OP_BNE:   w_take = (w_rs_val != w_rt_val);
      OP_ADDIU: begin w_wen = 1'b1; w_wdata = w_rs_val + w_simm; end
      OP_SLTI:  begin w_wen = 1'b1; w_wdata = {31'd0, $signed(w_rs_val) < $signed(w_simm)}; end
      OP_SLTIU: begin w_wen = 1'b1; w_wdata = {31'd0, w_rs_val < w_simm}; end
      OP_ANDI:  begin w_wen = 1'b1; w_wdata = w_rs_val & w_zimm; end
      OP_ORI:   begin w_wen = 1'b1; w_wdata = w_rs_val | w_zimm; end
      OP_XORI:  begin w_wen = 1'b1; w_wdata = w_rs_val ^ w_zimm; end
      OP_LUI:   begin w_wen = 1'b1; w_wdata = {instr_readdata[15:0], 16'd0}; end
      OP_LW:    begin w_wen = 1'b1; w_wdata = data_readdata; w_is_lw = 1'b1; end
      OP_SW:    w_is_sw = 1'b1;
      default:  ;
    endcase
  end

  // A taken branch/jump is remembered for one instruction so the delay slot
  // at PC+4 executes before control transfers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc             <= RESET_VECTOR;
      r_branch_pending <= 1'b0;
      r_branch_target  <= RESET_VECTOR;
    end else if (w_commit) begin
      r_pc             <= r_branch_pending ? r_branch_target : w_pc4;
      r_branch_pending <= w_take;
      r_branch_target  <= w_target;
    end
  end

  assign active         = w_active;
  assign instr_address  = r_pc;
  assign data_address   = w_rs_val + w_simm;
  assign data_writedata = w_rt_val;
  assign data_write     = w_active && w_is_sw && !reset;
  assign data_read      = w_active && w_is_lw && !reset;

`ifdef MIPS_CPU_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && w_commit) begin
      if (w_wen && (w_waddr != '0))
        $display("pc=%08h instr=%08h $%0d<=%08h", r_pc, instr_readdata, w_waddr, w_wdata);
      else
        $display("pc=%08h instr=%08h", r_pc, instr_readdata);
    end
  end
`else
`endif

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
module tb_mips_cpu_harvard_core;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        active;
  logic [31:0] register_v0, instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_write, data_read;

  logic [31:0] imem [256];
  logic [31:0] dmem [256] = '{default: '0};
  logic [31:0] w_off;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] v0;
    logic [1:0]  strobe;   // {data_read, data_write}
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mips_cpu_harvard_core dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .register_v0    (register_v0),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  // Address 0 holds ADDIU $2,$2,1 so a core that keeps running after halt is visible.
  assign w_off = instr_address - BASE;
  always_comb begin
    if (instr_address == 32'h0)   instr_readdata = 32'h2442_0001;
    else if (w_off < 32'd1024)    instr_readdata = imem[w_off[9:2]];
    else                          instr_readdata = '0;
  end

  assign data_readdata = dmem[data_address[9:2]];
  always @(posedge clk) if (data_write && clk_enable) dmem[data_address[9:2]] <= data_writedata;

  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [4:0] sh, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] f_j(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = '0;
    sb.delete();
  endtask

  task automatic put(input int off, input logic [31:0] w);
    imem[off / 4] = w;
  endtask

  task automatic step(input int off, input logic [31:0] v0, input logic [1:0] st = 2'b00,
                      input logic [31:0] addr = '0, input logic [31:0] wd = '0);
    exp_t e;
    e.pc = BASE + off; e.v0 = v0; e.strobe = st; e.addr = addr; e.wdata = wd;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clk_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Plays the scoreboard against the DUT one instruction per cycle, then checks the halt state.
  task automatic run_program(input string name, input logic [31:0] final_v0, input int stall_at);
    exp_t e;
    logic [31:0] prev_v0 = '0;
    int idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (idx == stall_at) begin
        clk_enable = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          n_vec++;
          if (instr_address !== e.pc || register_v0 !== prev_v0) begin
            n_bad++;
            $display("FAIL %s stall: pc %08h v0 %08h, want pc %08h v0 %08h",
                     name, instr_address, register_v0, e.pc, prev_v0);
          end
        end
        @(negedge clk);
        clk_enable = 1'b1;
      end
      n_vec++;
      if (instr_address !== e.pc) begin
        n_bad++;
        $display("FAIL %s pc[%0d]: got %08h want %08h", name, idx, instr_address, e.pc);
      end
      n_vec++;
      if ({data_read, data_write} !== e.strobe) begin
        n_bad++;
        $display("FAIL %s strobes[%0d]: got %b want %b", name, idx, {data_read, data_write}, e.strobe);
      end
      if (e.strobe != 2'b00) begin
        n_vec++;
        if (data_address !== e.addr) begin
          n_bad++;
          $display("FAIL %s daddr[%0d]: got %08h want %08h", name, idx, data_address, e.addr);
        end
      end
      if (e.strobe == 2'b01) begin
        n_vec++;
        if (data_writedata !== e.wdata) begin
          n_bad++;
          $display("FAIL %s wdata[%0d]: got %08h want %08h", name, idx, data_writedata, e.wdata);
        end
      end
      @(posedge clk); #1;
      n_vec++;
      if (register_v0 !== e.v0) begin
        n_bad++;
        $display("FAIL %s v0[%0d]: got %08h want %08h", name, idx, register_v0, e.v0);
      end
      prev_v0 = e.v0;
      @(negedge clk);
      idx++;
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (instr_address !== 32'h0 || active !== 1'b0 || register_v0 !== final_v0 ||
          {data_read, data_write} !== 2'b00) begin
        n_bad++;
        $display("FAIL %s halt[%0d]: pc %08h active %b v0 %08h rw %b, want 0 0 %08h 00",
                 name, k, instr_address, active, register_v0, {data_read, data_write}, final_v0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if (instr_address !== BASE || active !== 1'b1 || register_v0 !== 32'h0 ||
        {data_read, data_write} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset: pc %08h active %b v0 %08h, want %08h 1 0", instr_address, active, register_v0, BASE);
    end
    clear_prog();
    put(0, f_i(6'h09, 5'd0, 5'd2, 16'd5));
    put(4, f_i(6'h09, 5'd2, 5'd2, 16'd7));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (instr_address !== BASE + 32'd8 || register_v0 !== 32'd12) begin
      n_bad++;
      $display("FAIL pre_abort: pc %08h v0 %08h, want %08h 0000000c", instr_address, register_v0, BASE + 32'd8);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (instr_address !== BASE || register_v0 !== 32'h0 || active !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: pc %08h v0 %08h active %b, want %08h 0 1", instr_address, register_v0, active, BASE);
    end
    @(posedge clk); #1;
    n_vec++;
    if (instr_address !== BASE || register_v0 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_hold: pc %08h v0 %08h, want %08h 0", instr_address, register_v0, BASE);
    end
  endtask

  task automatic test_addiu();
    clear_prog();
    put(0,  f_i(6'h09, 5'd0, 5'd2, 16'd5));
    put(4,  f_i(6'h09, 5'd2, 5'd2, 16'd7));
    put(8,  f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
    step(0, 5); step(4, 12); step(8, 12); step(12, 12);
    do_reset();
    run_program("addiu", 32'd12, -1);
  endtask

  task automatic test_alu();
    clear_prog();
    put(32'h00, f_i(6'h09, 5'd0, 5'd1, 16'hFFF0));  step(32'h00, 32'h0);
    put(32'h04, f_i(6'h0F, 5'd0, 5'd2, 16'h1234));  step(32'h04, 32'h1234_0000);
    put(32'h08, f_i(6'h0D, 5'd2, 5'd2, 16'h8001));  step(32'h08, 32'h1234_8001);
    put(32'h0C, f_i(6'h0E, 5'd2, 5'd2, 16'hFFFF));  step(32'h0C, 32'h1234_7FFE);
    put(32'h10, f_i(6'h0C, 5'd1, 5'd2, 16'h8FF0));  step(32'h10, 32'h0000_8FF0);
    put(32'h14, f_r(5'd1, 5'd0, 5'd2, 5'd0, 6'h2A)); step(32'h14, 32'h1);
    put(32'h18, f_r(5'd1, 5'd0, 5'd2, 5'd0, 6'h2B)); step(32'h18, 32'h0);
    put(32'h1C, f_i(6'h0A, 5'd1, 5'd2, 16'hFFF1));  step(32'h1C, 32'h1);
    put(32'h20, f_i(6'h0B, 5'd1, 5'd2, 16'h0001));  step(32'h20, 32'h0);
    put(32'h24, f_r(5'd0, 5'd1, 5'd2, 5'd2, 6'h03)); step(32'h24, 32'hFFFF_FFFC);
    put(32'h28, f_r(5'd0, 5'd1, 5'd2, 5'd2, 6'h02)); step(32'h28, 32'h3FFF_FFFC);
    put(32'h2C, f_r(5'd0, 5'd1, 5'd2, 5'd4, 6'h00)); step(32'h2C, 32'hFFFF_FF00);
    put(32'h30, f_r(5'd1, 5'd2, 5'd2, 5'd0, 6'h26)); step(32'h30, 32'h0000_00F0);
    put(32'h34, f_r(5'd2, 5'd1, 5'd2, 5'd0, 6'h25)); step(32'h34, 32'hFFFF_FFF0);
    put(32'h38, f_r(5'd0, 5'd1, 5'd2, 5'd0, 6'h23)); step(32'h38, 32'h0000_0010);
    put(32'h3C, f_r(5'd2, 5'd1, 5'd2, 5'd0, 6'h24)); step(32'h3C, 32'h0000_0010);
    put(32'h40, f_r(5'd2, 5'd2, 5'd2, 5'd0, 6'h21)); step(32'h40, 32'h0000_0020);
    put(32'h44, f_i(6'h09, 5'd0, 5'd0, 16'd5));     step(32'h44, 32'h0000_0020);
    put(32'h48, f_r(5'd0, 5'd0, 5'd2, 5'd0, 6'h21)); step(32'h48, 32'h0);
    put(32'h4C, f_i(6'h09, 5'd2, 5'd2, 16'hFFFF));  step(32'h4C, 32'hFFFF_FFFF);
    put(32'h50, f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08)); step(32'h50, 32'hFFFF_FFFF);
    step(32'h54, 32'hFFFF_FFFF);
    do_reset();
    run_program("alu", 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_bltzal();
    clear_prog();
    put(32'h00, f_i(6'h09, 5'd0, 5'd1, 16'd32));
    put(32'h04, f_i(6'h09, 5'd0, 5'd3, 16'hFFE0));
    put(32'h08, f_i(6'h01, 5'd1, 5'h10, 16'd5));
    put(32'h0C, f_r(5'd31, 5'd0, 5'd2, 5'd0, 6'h21));
    put(32'h10, f_i(6'h01, 5'd3, 5'h10, 16'd3));
    put(32'h14, f_i(6'h09, 5'd2, 5'd2, 16'd1));
    put(32'h18, f_i(6'h09, 5'd2, 5'd2, 16'h100));
    put(32'h1C, f_i(6'h09, 5'd2, 5'd2, 16'h100));
    put(32'h20, f_r(5'd31, 5'd2, 5'd2, 5'd0, 6'h23));
    put(32'h24, f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
    step(32'h00, 0); step(32'h04, 0); step(32'h08, 0);
    step(32'h0C, BASE + 32'h10);
    step(32'h10, BASE + 32'h10);
    step(32'h14, BASE + 32'h11);
    step(32'h20, 32'd7); step(32'h24, 32'd7); step(32'h28, 32'd7);
    do_reset();
    run_program("bltzal", 32'd7, -1);
  endtask

  task automatic test_chain(input int stall_at);
    clear_prog();
    put(32'h00, f_i(6'h09, 5'd0, 5'd1, 16'd32));
    put(32'h04, f_r(5'd0, 5'd1, 5'd3, 5'd0, 6'h23));
    put(32'h08, f_i(6'h01, 5'd1, 5'h10, 16'd5));
    put(32'h0C, f_r(5'd31, 5'd0, 5'd4, 5'd0, 6'h21));
    put(32'h10, f_i(6'h01, 5'd3, 5'h10, 16'd25));
    put(32'h14, f_r(5'd31, 5'd0, 5'd5, 5'd0, 6'h21));
    put(32'h18, f_i(6'h09, 5'd1, 5'd1, 16'd1000));
    put(32'h78, f_i(6'h01, 5'd3, 5'h10, 16'd9));
    put(32'h7C, f_r(5'd31, 5'd0, 5'd6, 5'd0, 6'h21));
    put(32'h80, f_i(6'h09, 5'd1, 5'd1, 16'd1000));
    put(32'hA0, f_r(5'd6, 5'd4, 5'd7, 5'd0, 6'h23));
    put(32'hA4, f_r(5'd7, 5'd1, 5'd2, 5'd0, 6'h21));
    put(32'hA8, f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
    step(32'h00, 0); step(32'h04, 0); step(32'h08, 0); step(32'h0C, 0);
    step(32'h10, 0); step(32'h14, 0); step(32'h78, 0); step(32'h7C, 0);
    step(32'hA0, 0); step(32'hA4, 32'd144); step(32'hA8, 32'd144); step(32'hAC, 32'd144);
    do_reset();
    run_program(stall_at < 0 ? "chain" : "chain_stall", 32'd144, stall_at);
  endtask

  task automatic test_jumps();
    clear_prog();
    put(32'h00, f_i(6'h09, 5'd0, 5'd1, 16'd3));
    put(32'h04, f_i(6'h04, 5'd1, 5'd0, 16'd10));
    put(32'h08, f_i(6'h09, 5'd0, 5'd2, 16'd1));
    put(32'h0C, f_i(6'h05, 5'd1, 5'd0, 16'd4));
    put(32'h10, f_i(6'h09, 5'd2, 5'd2, 16'd2));
    put(32'h14, f_i(6'h09, 5'd2, 5'd2, 16'd100));
    put(32'h20, f_j(6'h03, BASE + 32'h40));
    put(32'h24, f_r(5'd2, 5'd1, 5'd2, 5'd0, 6'h21));
    put(32'h28, f_r(5'd9, 5'd31, 5'd2, 5'd0, 6'h23));
    put(32'h2C, f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
    put(32'h40, f_r(5'd31, 5'd0, 5'd9, 5'd0, 6'h09));
    put(32'h44, f_i(6'h09, 5'd2, 5'd2, 16'd10));
    step(32'h00, 0); step(32'h04, 0); step(32'h08, 1); step(32'h0C, 1);
    step(32'h10, 3); step(32'h20, 3); step(32'h24, 6); step(32'h40, 6);
    step(32'h44, 16); step(32'h28, 32); step(32'h2C, 32); step(32'h30, 32);
    do_reset();
    run_program("jumps", 32'd32, -1);
  endtask

  task automatic test_mem();
    clear_prog();
    put(32'h00, f_i(6'h0F, 5'd0, 5'd5, 16'hDEAD));
    put(32'h04, f_i(6'h0D, 5'd5, 5'd5, 16'hBEEF));
    put(32'h08, f_i(6'h09, 5'd0, 5'd6, 16'h0100));
    put(32'h0C, f_i(6'h2B, 5'd6, 5'd5, 16'h0000));
    put(32'h10, f_i(6'h23, 5'd6, 5'd2, 16'h0000));
    put(32'h14, f_r(5'd0, 5'd0, 5'd0, 5'd0, 6'h08));
    step(32'h00, 0); step(32'h04, 0); step(32'h08, 0);
    step(32'h0C, 0, 2'b01, 32'h100, 32'hDEAD_BEEF);
    step(32'h10, 32'hDEAD_BEEF, 2'b10, 32'h100);
    step(32'h14, 32'hDEAD_BEEF); step(32'h18, 32'hDEAD_BEEF);
    do_reset();
    run_program("mem", 32'hDEAD_BEEF, -1);
  endtask

  initial begin
    test_reset();
    test_addiu();
    test_alu();
    test_bltzal();
    test_chain(-1);
    test_chain(7);
    test_jumps();
    test_mem();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_cpu_harvard_core.md
# mips_cpu_harvard_core

Single-cycle, 32-bit big-endian-agnostic MIPS-I integer core with separate instruction and data buses (Harvard). It fetches through a combinational instruction port, accesses a separate data memory (mips_cpu_data_memory) through a word-wide port, and halts when control reaches address 0. It sits at the top of the CPU subsystem. Register $v0 is exported for test observation.

## Interface
No parameters. Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock for all state
- reset  in  1  asynchronous, active-high; forces reset state immediately
- clk_enable  in  1  when 0, all architectural state holds
- active  out  1  1 while running; 0 once halted
- register_v0  out  32  live value of GPR $2
- instr_address  out  32  current PC
- instr_readdata  in  32  instruction at instr_address, valid the same cycle
- data_address  out  32  byte address, word-aligned, for LW/SW
- data_write  out  1  store strobe, sampled by memory on rising clk
- data_read  out  1  load strobe
- data_writedata  out  32  store data (rt)
- data_readdata  in  32  load data, combinational from data_address, same cycle

## Operation
- Reset and power-up state: PC=0xBFC00000, all GPRs 0, active=1, branch-pending flag 0. Same values are the declaration initialisers, so the core runs correctly if reset is never asserted.
- Supported instructions:
  - ALU: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI.
  - Memory: LW, SW.
  - Branch: BEQ, BNE, BLTZ, BGEZ, BLTZAL, BGEZAL.
  - Jump: J, JAL, JR, JALR.
  - Any other encoding executes as NOP.
- Arithmetic is 32-bit wrap-around; no overflow traps. ADDIU and SLTI sign-extend the immediate; ANDI, ORI and XORI zero-extend.
- $0 always reads 0; writes to it are discarded.
- Branch delay slot, always executed:
  - Branch target = PC+4 + (sign-extended offset << 2).
  - J/JAL target = {PC+4[31:28], index, 2'b00}.
  - JR/JALR target = rs.
- Link: BLTZAL and BGEZAL write $31=PC+8 unconditionally, whether taken or not. JAL writes $31=PC+8. JALR writes rd=PC+8.
- Compare for BLTZ/BLTZAL/BGEZ/BGEZAL uses rs as signed.
- Halt: when the PC becomes 0 (a jump to 0 after its delay slot):
  - active=0, instr_address stays 0.
  - No further GPR writes or data_write pulses.
  - register_v0 remains valid.

## Timing
- One instruction per enabled cycle.
- GPR write, PC update and store all occur on the rising clk edge with clk_enable=1.
- Loads complete in the same cycle because data_readdata is combinational.
- data_read and data_write are asserted combinationally only during LW and SW respectively; both are 0 when halted or in reset.
- Asserting reset mid-program aborts the in-flight instruction and any pending delay-slot branch.
- register_v0 updates the cycle after the writing instruction's edge.

## Configuration
- MIPS_CPU_TRACE_EN defined: after each retired instruction, the core prints the PC, the instruction word and any GPR write via $display.
- Not defined: no trace output; port behaviour is identical either way.

## Structure
- Package mips_cpu_pkg holds:
  - opcode, funct and REGIMM rt enums
  - the reset vector constant 0xBFC00000
  - the halt address constant 0
- One sub-module, mips_cpu_regfile: 32x32, two combinational read ports, one write port, async reset, plus a $2 tap for register_v0.
- The data memory (mips_cpu_data_memory) is a separate block. It writes on rising clk when data_write and clk_enable are high, and reads combinationally.

## Test plan
- Reset then hold: reset=1 -> instr_address=0xBFC00000, active=1, register_v0=0.
- ADDIU $2,$0,5; ADDIU $2,$2,7; JR $0; NOP -> halt with instr_address=0, active=0, register_v0=12.
- BLTZAL on $1=32 (not taken) -> $31=PC+8 still written. BLTZAL on $3=-32 (taken) -> delay slot executes, PC=target.
- Full chain: ADDIU $1=32; SUBU $3=-32; then three BLTZALs with delay slots; SUBU of two captured links; ADDU into $2 -> register_v0=144 at halt.
- SW $t=0xDEADBEEF to 0x100, then LW back into $2, then JR $0 -> register_v0=0xDEADBEEF.
- clk_enable=0 for 5 cycles mid-program -> PC and registers frozen; the program resumes and produces the same final v0.
